// File: rtl/fifo_burst_reader.sv
// Burst drain engine for a normal-mode fifo: pulls words in bursts of up to BURST_LEN
// (or a partial burst after TIMEOUT idle cycles) and replays them on a valid/ready stream with last.
module fifo_burst_reader #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned AWIDTH    = 3,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              busy_o
);

  localparam int unsigned CW    = AWIDTH + 1;
  localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 len_q, len_d;
  logic [CW-1:0]                 issued_q, issued_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic                          inflight_q, inflight_d;
  logic                          last_inflight_q, last_inflight_d;
  logic [DEPTH-1:0][DWIDTH-1:0]  buf_data_q, buf_data_d;
  logic [DEPTH-1:0]              buf_last_q, buf_last_d;
  logic [1:0]                    wr_ptr_q, wr_ptr_d;
  logic [1:0]                    rd_ptr_q, rd_ptr_d;
  logic [1:0]                    buf_cnt_q, buf_cnt_d;
  logic                          last_read_c;
  logic                          push_c;
  logic                          pop_c;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, burst length latch, issue counter and occupancy timer
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    timer_d  = '0;
    unique case (state_q)
      IDLE: begin
        issued_d = '0;
        if (fifo_usedw_i >= CW'(BURST_LEN)) begin
          len_d   = CW'(BURST_LEN);
          state_d = BURST;
        end else if (fifo_usedw_i != '0 && TIMEOUT != 0) begin
          if (timer_q == TW'(TIMEOUT - 1)) begin
            len_d   = fifo_usedw_i;
            state_d = BURST;
          end else begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
          end
        end
      end
      BURST: begin
        if (fifo_rdreq_o) begin
          issued_d = issued_q + CW'(1);
          if (last_read_c) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (buf_cnt_q == 2'd0 && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only; m_ready_i never reaches fifo_rdreq_o
  always_comb begin
    fifo_rdreq_o = 1'b0;
    last_read_c  = (issued_q + CW'(1)) == len_q;
    busy_o       = (state_q != IDLE);
    m_valid_o    = (buf_cnt_q != 2'd0);
    m_data_o     = buf_data_q[rd_ptr_q];
    m_last_o     = buf_last_q[rd_ptr_q];
    if (state_q == BURST && !fifo_empty_i && issued_q < len_q &&
        (3'(buf_cnt_q) + 3'(inflight_q)) < 3'd3) begin
      fifo_rdreq_o = 1'b1;
    end
  end

  // Output buffer: the third slot absorbs the word still in flight from the fifo
  always_comb begin
    inflight_d      = fifo_rdreq_o;
    last_inflight_d = fifo_rdreq_o && last_read_c;
    push_c          = inflight_q;
    pop_c           = m_valid_o && m_ready_i;
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    buf_cnt_d       = buf_cnt_q;
    if (push_c) begin
      buf_data_d[wr_ptr_q] = fifo_q_i;
      buf_last_d[wr_ptr_q] = last_inflight_q;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push_c, pop_c})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      len_q           <= '0;
      issued_q        <= '0;
      timer_q         <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      buf_data_q      <= '0;
      buf_last_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      buf_cnt_q       <= '0;
    end else begin
      len_q           <= len_d;
      issued_q        <= issued_d;
      timer_q         <= timer_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      buf_cnt_q       <= buf_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural fifo, stream scoreboard, table-driven burst check,
// hand-written corner sequences and a randomized run. Two instances cover TIMEOUT=16 and TIMEOUT=0.
module tb_fifo_burst_reader;

  localparam int unsigned BL = 4;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic       rdy;
    logic       rd;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       b;
  } vec_t;

  logic       clk = 1'b0;
  logic       arstn_i;
  logic [7:0] fifo_q;
  int         fcnt;
  logic       force_empty;
  logic       sel;
  logic       m_ready;
  logic [3:0] usedw, usedw_a, usedw_b;
  logic       empty_eff, empty_a, empty_b;
  logic       rd_a, valid_a, last_a, busy_a;
  logic       rd_b, valid_b, last_b, busy_b;
  logic [7:0] data_a, data_b;
  logic       rd_m, valid_m, last_m, busy_m;
  logic [7:0] data_m;

  always #5 clk = ~clk;

  assign usedw     = 4'(fcnt);
  assign empty_eff = (fcnt == 0) || force_empty;
  assign usedw_a   = sel ? 4'd0 : usedw;
  assign empty_a   = sel ? 1'b1 : empty_eff;
  assign usedw_b   = sel ? usedw : 4'd0;
  assign empty_b   = sel ? empty_eff : 1'b1;
  assign rd_m      = sel ? rd_b : rd_a;
  assign valid_m   = sel ? valid_b : valid_a;
  assign data_m    = sel ? data_b : data_a;
  assign last_m    = sel ? last_b : last_a;
  assign busy_m    = sel ? busy_b : busy_a;

  fifo_burst_reader #(.DWIDTH(8), .AWIDTH(3), .BURST_LEN(BL), .TIMEOUT(16)) dut_a (
    .clk_i(clk), .arstn_i(arstn_i), .fifo_q_i(fifo_q), .fifo_empty_i(empty_a),
    .fifo_usedw_i(usedw_a), .fifo_rdreq_o(rd_a), .m_data_o(data_a), .m_valid_o(valid_a),
    .m_ready_i(m_ready), .m_last_o(last_a), .busy_o(busy_a));

  fifo_burst_reader #(.DWIDTH(8), .AWIDTH(3), .BURST_LEN(BL), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .arstn_i(arstn_i), .fifo_q_i(fifo_q), .fifo_empty_i(empty_b),
    .fifo_usedw_i(usedw_b), .fifo_rdreq_o(rd_b), .m_data_o(data_b), .m_valid_o(valid_b),
    .m_ready_i(m_ready), .m_last_o(last_b), .busy_o(busy_b));

  logic [7:0] mem[$];
  logic [7:0] wr_q[$];
  beat_t      sb[$];
  int         errors = 0;
  int         checks = 0;
  int         burst_reads, exp_len, prev_cnt, outstanding, beats;
  logic       prev_v, prev_rdy, prev_l;
  logic [7:0] prev_d;
  logic       s_rd, s_v, s_l, s_bsy;
  logic [7:0] s_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mem.delete();
    wr_q.delete();
    sb.delete();
    fifo_q      = 8'h00;
    fcnt        = 0;
    burst_reads = 0;
    exp_len     = 0;
    prev_cnt    = 0;
    outstanding = 0;
    prev_v      = 1'b0;
    prev_rdy    = 1'b0;
    prev_l      = 1'b0;
    prev_d      = 8'h00;
  endtask

  // One clock: sample and score at mid-cycle, then advance the fifo model past the rising edge.
  task automatic step();
    beat_t e;
    logic  rd_now;
    #1;
    s_rd  = rd_m;
    s_v   = valid_m;
    s_d   = data_m;
    s_l   = last_m;
    s_bsy = busy_m;
    if (prev_v && !prev_rdy) begin
      chk("hold_valid", 32'(s_v), 32'd1);
      chk("hold_data", 32'(s_d), 32'(prev_d));
      chk("hold_last", 32'(s_l), 32'(prev_l));
    end
    chk("occupancy_le3", 32'(outstanding <= 3), 32'd1);
    if (s_rd) begin
      chk("rdreq_while_empty", 32'(empty_eff), 32'd0);
      if (burst_reads == 0) exp_len = (prev_cnt < int'(BL)) ? prev_cnt : int'(BL);
      burst_reads++;
      e.d = (mem.size() > 0) ? mem[0] : 8'h00;
      e.l = (burst_reads == exp_len);
      sb.push_back(e);
      if (burst_reads >= exp_len) burst_reads = 0;
      outstanding++;
    end
    if (s_v && m_ready) begin
      beats++;
      outstanding--;
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_data", 32'(s_d), 32'(e.d));
        chk("beat_last", 32'(s_l), 32'(e.l));
      end
    end
    prev_v   = s_v;
    prev_rdy = m_ready;
    prev_d   = s_d;
    prev_l   = s_l;
    prev_cnt = fcnt;
    rd_now   = s_rd;
    @(posedge clk);
    #1;
    if (rd_now && mem.size() > 0) fifo_q = mem.pop_front();
    while (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
    fcnt = mem.size();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[9];
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         pat[5];
    int         first, cnt, lasts, written, b0;

    tbl[0] = '{rdy: 1'b1, rd: 1'b0, v: 1'b0, d: 8'h00, l: 1'b0, b: 1'b0};
    tbl[1] = '{rdy: 1'b1, rd: 1'b1, v: 1'b0, d: 8'h00, l: 1'b0, b: 1'b1};
    tbl[2] = '{rdy: 1'b1, rd: 1'b1, v: 1'b0, d: 8'h00, l: 1'b0, b: 1'b1};
    tbl[3] = '{rdy: 1'b1, rd: 1'b1, v: 1'b1, d: 8'h11, l: 1'b0, b: 1'b1};
    tbl[4] = '{rdy: 1'b1, rd: 1'b1, v: 1'b1, d: 8'h12, l: 1'b0, b: 1'b1};
    tbl[5] = '{rdy: 1'b1, rd: 1'b0, v: 1'b1, d: 8'h13, l: 1'b0, b: 1'b1};
    tbl[6] = '{rdy: 1'b1, rd: 1'b0, v: 1'b1, d: 8'h14, l: 1'b1, b: 1'b1};
    tbl[7] = '{rdy: 1'b1, rd: 1'b0, v: 1'b0, d: 8'h00, l: 1'b0, b: 1'b1};
    tbl[8] = '{rdy: 1'b1, rd: 1'b0, v: 1'b0, d: 8'h00, l: 1'b0, b: 1'b0};
    pat = '{1, 0, 0, 1, 0};

    model_clear();
    beats       = 0;
    arstn_i     = 1'b0;
    m_ready     = 1'b0;
    sel         = 1'b0;
    force_empty = 1'b0;

    // Reset values before any clock edge
    #2;
    chk("rst_rdreq", 32'({rd_a, rd_b}), 32'd0);
    chk("rst_valid", 32'({valid_a, valid_b}), 32'd0);
    chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    chk("rst_data", 32'({data_a, data_b}), 32'd0);
    chk("rst_last", 32'({last_a, last_b}), 32'd0);
    @(negedge clk);
    arstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_busy", 32'(s_bsy), 32'd0);
      chk("idle_rdreq", 32'(s_rd), 32'd0);
    end

    // Full burst with ready held high, cycle-exact
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr_q.push_back(8'h11 + 8'(i));
    step();
    for (int i = 0; i < 9; i++) begin
      m_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_rdreq", i), 32'(s_rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_valid", i), 32'(s_v), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_busy", i), 32'(s_bsy), 32'(tbl[i].b));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_data", i), 32'(s_d), 32'(tbl[i].d));
        chk($sformatf("tbl%0d_last", i), 32'(s_l), 32'(tbl[i].l));
      end
    end

    // Partial burst after the occupancy timeout
    wr_q.push_back(8'hA0);
    wr_q.push_back(8'hA1);
    step();
    first = -1;
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 40; c++) begin
      step();
      if (s_rd && first < 0) first = c;
      if (s_v && m_ready) begin
        got_d.push_back(s_d);
        got_l.push_back(s_l);
      end
    end
    chk("to_first_rdreq_cycle", 32'(first), 32'd16);
    chk("to_beat_count", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("to_beat0", 32'({got_d[0], got_l[0]}), 32'({8'hA0, 1'b0}));
      chk("to_beat1", 32'({got_d[1], got_l[1]}), 32'({8'hA1, 1'b1}));
    end
    chk("to_idle_after", 32'(s_bsy), 32'd0);

    // Eight words drained under a stalling ready pattern
    for (int i = 0; i < 8; i++) wr_q.push_back(8'h40 + 8'(i));
    step();
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 80; c++) begin
      m_ready = pat[c % 5][0];
      step();
      if (s_v && m_ready) begin
        got_d.push_back(s_d);
        got_l.push_back(s_l);
      end
    end
    chk("stall_beat_count", 32'(got_d.size()), 32'd8);
    for (int i = 0; i < got_d.size() && i < 8; i++)
      chk($sformatf("stall_beat%0d", i), 32'({got_d[i], got_l[i]}),
          32'({8'h40 + 8'(i), 1'(i == 3 || i == 7)}));

    // Reset asserted mid-burst after the second beat
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr_q.push_back(8'h50 + 8'(i));
    step();
    b0 = beats;
    for (int c = 0; c < 20 && beats - b0 < 2; c++) step();
    chk("mid_beats_before_reset", 32'(beats - b0), 32'd2);
    arstn_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_rdreq", 32'(rd_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_data", 32'(data_a), 32'd0);
    chk("mid_rst_last", 32'(last_a), 32'd0);
    model_clear();
    step();
    step();
    arstn_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_v || s_bsy || s_rd) cnt++;
    end
    chk("post_reset_quiet_cycles", 32'(cnt), 32'd0);

    // TIMEOUT disabled: short occupancy never starts, empty flag stalls the burst
    sel = 1'b1;
    for (int i = 0; i < 3; i++) wr_q.push_back(8'h60 + 8'(i));
    step();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (s_rd || s_bsy) cnt++;
    end
    chk("nto_no_start", 32'(cnt), 32'd0);
    wr_q.push_back(8'h63);
    step();
    step();
    chk("nto_c0_rdreq", 32'(s_rd), 32'd0);
    step();
    chk("nto_c1_rdreq", 32'(s_rd), 32'd1);
    force_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("empty_blocks_rdreq", 32'(s_rd), 32'd0);
      chk("empty_keeps_busy", 32'(s_bsy), 32'd1);
    end
    force_empty = 1'b0;
    b0 = beats;
    step();
    chk("empty_clear_resumes", 32'(s_rd), 32'd1);
    lasts = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_v && m_ready && s_l) lasts++;
    end
    chk("nto_beat_count", 32'(beats - b0 + 1), 32'd4);
    chk("nto_last_count", 32'(lasts), 32'd1);
    chk("nto_idle_after", 32'(s_bsy), 32'd0);

    // Randomized traffic against the scoreboard
    sel     = 1'b0;
    written = 0;
    b0      = beats;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, (c < 300) ? 2 : 11) == 0 && mem.size() + wr_q.size() < 8) begin
        wr_q.push_back(8'($urandom));
        written++;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 80; c++) step();
    chk("rand_all_delivered", 32'(beats - b0), 32'(written));
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_idle_after", 32'(s_bsy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
